// File: rtl/keypoint_reader.sv
// keypoint_reader: drains the two keypoint SRAM banks after detection and
// streams (row, col, scale, last) downstream through a 2-entry output FIFO.
module keypoint_reader #(
    parameter int ADDR_W = 11,
    parameter int ROW_W  = 9,
    parameter int COL_W  = 10,
    parameter int CNT_W  = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       kp1_count,
    input  logic [CNT_W-1:0]       kp2_count,
    output logic                   busy,
    output logic                   done,
    output logic                   keypoint_1_re,
    output logic [ADDR_W-1:0]      keypoint_1_addr,
    input  logic [ROW_W+COL_W-1:0] keypoint_1_dout,
    output logic                   keypoint_2_re,
    output logic [ADDR_W-1:0]      keypoint_2_addr,
    input  logic [ROW_W+COL_W-1:0] keypoint_2_dout,
    output logic                   kp_valid,
    input  logic                   kp_ready,
    output logic [ROW_W-1:0]       kp_row,
    output logic [COL_W-1:0]       kp_col,
    output logic                   kp_scale,
    output logic                   kp_last
);

    localparam int DW = ROW_W + COL_W;
    localparam int EW = DW + 2;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(2 ** ADDR_W);

    typedef enum logic [2:0] {IDLE, READ1, READ2, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic              infl_q, infl_d;
    logic              infl_scale_q, infl_scale_d;
    logic              infl_last_q, infl_last_d;
    logic [EW-1:0]     mem_q [2];
    logic [EW-1:0]     mem_d [2];
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [1:0]        occ_q, occ_d;

    logic          pop, push, can_issue, last_idx;
    logic          re1, re2, issue;
    logic [2:0]    load;
    logic [EW-1:0] head, entry;

    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] c);
        return (c > MAX_CNT) ? MAX_CNT : c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) begin
                if (clamp(kp1_count) != '0)      state_d = READ1;
                else if (clamp(kp2_count) != '0) state_d = READ2;
                else                             state_d = DRAIN;
            end
            READ1: if (re1 && last_idx) state_d = (cnt2_q != '0) ? READ2 : DRAIN;
            READ2: if (re2 && last_idx) state_d = DRAIN;
            DRAIN: if (!infl_q && occ_q == 2'd0) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Issue only while buffered + in-flight entries, net of this cycle's pop, leave room.
    always_comb begin
        pop       = (occ_q != 2'd0) && kp_ready;
        load      = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, pop};
        can_issue = load < 3'd2;
        re1       = (state_q == READ1) && can_issue;
        re2       = (state_q == READ2) && can_issue;
        issue     = re1 || re2;
        last_idx  = (state_q == READ1) ? (idx_q == cnt1_q - 1'b1)
                                       : (idx_q == cnt2_q - 1'b1);
        head      = mem_q[rd_q];
        entry     = {infl_last_q, infl_scale_q,
                     infl_scale_q ? keypoint_2_dout : keypoint_1_dout};
        push      = infl_q;

        busy            = state_q != IDLE;
        done            = state_q == DONE;
        keypoint_1_re   = re1;
        keypoint_2_re   = re2;
        keypoint_1_addr = re1 ? idx_q[ADDR_W-1:0] : addr1_q;
        keypoint_2_addr = re2 ? idx_q[ADDR_W-1:0] : addr2_q;
        kp_valid        = occ_q != 2'd0;
        kp_last         = head[EW-1];
        kp_scale        = head[EW-2];
        kp_row          = head[DW-1:COL_W];
        kp_col          = head[COL_W-1:0];
    end

    always_comb begin
        cnt1_d       = cnt1_q;
        cnt2_d       = cnt2_q;
        idx_d        = idx_q;
        addr1_d      = keypoint_1_addr;
        addr2_d      = keypoint_2_addr;
        infl_d       = issue;
        infl_scale_d = re2;
        infl_last_d  = issue && last_idx && (re2 || cnt2_q == '0);
        mem_d        = mem_q;
        wr_d         = wr_q ^ push;
        rd_d         = rd_q ^ pop;
        occ_d        = occ_q + {1'b0, push} - {1'b0, pop};
        if (state_q == IDLE) begin
            idx_d = '0;
            if (start) begin
                cnt1_d = clamp(kp1_count);
                cnt2_d = clamp(kp2_count);
            end
        end else if (issue) begin
            idx_d = last_idx ? '0 : idx_q + 1'b1;
        end
        if (push) mem_d[wr_q] = entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt1_q       <= '0;
            cnt2_q       <= '0;
            idx_q        <= '0;
            addr1_q      <= '0;
            addr2_q      <= '0;
            infl_q       <= 1'b0;
            infl_scale_q <= 1'b0;
            infl_last_q  <= 1'b0;
            mem_q[0]     <= '0;
            mem_q[1]     <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            occ_q        <= 2'd0;
        end else begin
            assert (!(push && !pop && occ_q == 2'd2))
                else $error("keypoint_reader: output fifo overflow");
            cnt1_q       <= cnt1_d;
            cnt2_q       <= cnt2_d;
            idx_q        <= idx_d;
            addr1_q      <= addr1_d;
            addr2_q      <= addr2_d;
            infl_q       <= infl_d;
            infl_scale_q <= infl_scale_d;
            infl_last_q  <= infl_last_d;
            mem_q        <= mem_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            occ_q        <= occ_d;
        end
    end

endmodule

// File: tb/tb_keypoint_reader.sv
// Directed bench for keypoint_reader: table of drain passes plus a
// mid-stream reset sequence, with an SRAM model and an expected-entry queue.
module tb_keypoint_reader;

    localparam int ADDR_W = 11;
    localparam int ROW_W  = 9;
    localparam int COL_W  = 10;
    localparam int CNT_W  = 12;
    localparam int DW     = ROW_W + COL_W;

    logic              clk = 1'b0;
    logic              rst, start, busy, done;
    logic [CNT_W-1:0]  kp1_count, kp2_count;
    logic              re1, re2;
    logic [ADDR_W-1:0] addr1, addr2;
    logic [DW-1:0]     dout1, dout2;
    logic              kp_valid, kp_ready;
    logic [ROW_W-1:0]  kp_row;
    logic [COL_W-1:0]  kp_col;
    logic              kp_scale, kp_last;

    keypoint_reader dut (
        .clk(clk), .rst(rst), .start(start),
        .kp1_count(kp1_count), .kp2_count(kp2_count),
        .busy(busy), .done(done),
        .keypoint_1_re(re1), .keypoint_1_addr(addr1), .keypoint_1_dout(dout1),
        .keypoint_2_re(re2), .keypoint_2_addr(addr2), .keypoint_2_dout(dout2),
        .kp_valid(kp_valid), .kp_ready(kp_ready),
        .kp_row(kp_row), .kp_col(kp_col),
        .kp_scale(kp_scale), .kp_last(kp_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] bank1 [2048];
    logic [DW-1:0] bank2 [2048];

    always @(posedge clk) begin
        if (re1) dout1 <= bank1[addr1];
        if (re2) dout2 <= bank2[addr2];
    end

    typedef struct {
        int            k1, k2, mode;
        logic [DW-1:0] b2f;
        int            beats, first_v, done_off, n1, n2;
    } vec_t;

    int total = 0, bad = 0;
    int cyc = 0, start_cyc;
    int first_valid, done_off, done_cnt, n_re1, n_re2, both_re;
    int addr_err, beats, beat_err, stall_err, out_err;
    int issued, popped, next_a1, next_a2;
    logic          prev_stall;
    logic [DW+1:0] prev_head, head;
    logic [DW+1:0] expq [$];
    logic [6:0]    pat = 7'b1101001;
    vec_t          vecs [7];

    function automatic logic [DW-1:0] mk(input int r, input int c);
        return {ROW_W'(r), COL_W'(c)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        head = {kp_last, kp_scale, kp_row, kp_col};
        if (re1 && re2) both_re++;
        if (re1) begin
            n_re1++; issued++;
            if (int'(addr1) != next_a1) addr_err++;
            next_a1++;
        end
        if (re2) begin
            n_re2++; issued++;
            if (int'(addr2) != next_a2) addr_err++;
            next_a2++;
        end
        if (prev_stall && (!kp_valid || head !== prev_head)) stall_err++;
        if (kp_valid && first_valid < 0) first_valid = cyc - start_cyc;
        if (kp_valid && kp_ready) begin
            popped++; beats++;
            if (expq.size() == 0) beat_err++;
            else begin
                if (head !== expq[0]) beat_err++;
                expq.delete(0);
            end
        end
        if (issued - popped > 2) out_err++;
        prev_stall = kp_valid && !kp_ready;
        prev_head  = head;
        if (done) begin
            done_cnt++;
            done_off = cyc - start_cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        first_valid = -1; done_off = -1; done_cnt = 0;
        n_re1 = 0; n_re2 = 0; both_re = 0; addr_err = 0;
        beats = 0; beat_err = 0; stall_err = 0; out_err = 0;
        issued = 0; popped = 0; next_a1 = 0; next_a2 = 0;
        prev_stall = 1'b0;
        expq.delete();
    endtask

    task automatic run_pass(input vec_t v, input int extra_start);
        int n1, n2, k;
        clear_stats();
        bank2[0] = v.b2f;
        n1 = (v.k1 > 2048) ? 2048 : v.k1;
        n2 = (v.k2 > 2048) ? 2048 : v.k2;
        for (int i = 0; i < n1; i++)
            expq.push_back({(n2 == 0 && i == n1 - 1), 1'b0, bank1[i]});
        for (int i = 0; i < n2; i++)
            expq.push_back({(i == n2 - 1), 1'b1, bank2[i]});
        kp1_count = CNT_W'(v.k1);
        kp2_count = CNT_W'(v.k2);
        start_cyc = cyc + 1;
        for (int i = 0; i < 6000 && done_cnt == 0; i++) begin
            k = cyc + 1 - start_cyc;
            kp_ready = (v.mode == 0) ? 1'b1 : pat[k % 7];
            start = (k == 0) || (extra_start > 0 && k == extra_start);
            tick();
        end
        start = 1'b0;
        kp_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("beats", beats, v.beats);
        check("beat_data", beat_err, 0);
        check("expected_left", expq.size(), 0);
        check("first_valid", first_valid, v.first_v);
        if (v.done_off > 0) check("done_cycle", done_off, v.done_off);
        check("done_pulses", done_cnt, 1);
        check("re1_count", n_re1, v.n1);
        check("re2_count", n_re2, v.n2);
        check("both_re", both_re, 0);
        check("addr_seq", addr_err, 0);
        check("outstanding", out_err, 0);
        check("stall_stable", stall_err, 0);
        check("idle_after", int'(busy), 0);
    endtask

    initial begin
        vec_t rv;
        for (int i = 0; i < 2048; i++) begin
            bank1[i] = DW'(i * 37 + 11);
            bank2[i] = DW'(i * 53 + 7);
        end
        bank1[0] = mk(5, 7);
        bank1[1] = mk(9, 100);
        bank1[2] = mk(479, 639);
        bank2[1] = mk(3, 4);

        //        k1    k2  mode  bank2[0]       beats first done  re1   re2
        vecs[0] = '{3,    2,  0,  mk(1, 2),      5,    3,    9,    3,    2};
        vecs[1] = '{3,    2,  1,  mk(1, 2),      5,    3,    0,    3,    2};
        vecs[2] = '{0,    0,  0,  mk(1, 2),      0,    -1,   2,    0,    0};
        vecs[3] = '{0,    1,  0,  mk(200, 300),  1,    3,    5,    0,    1};
        vecs[4] = '{1,    0,  0,  mk(1, 2),      1,    3,    5,    1,    0};
        vecs[5] = '{2048, 0,  0,  mk(1, 2),      2048, 3,    2052, 2048, 0};
        vecs[6] = '{4095, 0,  0,  mk(1, 2),      2048, 3,    2052, 2048, 0};

        rst = 1'b1; start = 1'b0; kp_ready = 1'b1;
        kp1_count = '0; kp2_count = '0;
        clear_stats();
        start_cyc = 0;
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(kp_valid), 0);
        check("rst_re", int'(re1) + int'(re2), 0);
        check("rst_fields", int'(kp_row) + int'(kp_col) + int'(kp_last), 0);
        rst = 1'b0;
        tick();

        for (int t = 0; t < 7; t++) run_pass(vecs[t], 0);

        // Abort a pass after two beats, then replay with a stray start while busy.
        clear_stats();
        bank2[0] = mk(1, 2);
        kp1_count = 12'd3; kp2_count = 12'd2; kp_ready = 1'b1;
        start_cyc = cyc + 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && beats < 2; i++) tick();
        check("pre_abort_beats", beats, 2);
        rst = 1'b1;
        #1;
        check("abort_valid", int'(kp_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_re", int'(re1) + int'(re2), 0);
        check("abort_done", int'(done), 0);
        done_cnt = 0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort_no_done", done_cnt, 0);
        rv = vecs[0];
        run_pass(rv, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
